// File: rtl/noc_ni_rx_responder.sv
// AXI-Lite write responder at the PE end of a mesh NI link: accepts routed messages, filters on destination, buffers them for the PE.
// Optional build macro NI_PARITY_CHECK_EN: s_wdata[0] carries even parity over the message; failures answer SLVERR.
module noc_ni_rx_responder #(
    parameter int MSG_WIDTH  = 128,
    parameter int ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int LOCAL_ADR  = 0,
    parameter int SIZE_X     = 4,
    parameter int SIZE_Y     = 4
) (
    input  logic                        clk,
    input  logic                        arst_n,
    input  logic                        s_awvalid,
    output logic                        s_awready,
    input  logic [ADDR_WIDTH-1:0]       s_awaddr,
    input  logic                        s_wvalid,
    output logic                        s_wready,
    input  logic [MSG_WIDTH-1:0]        s_wdata,
    output logic                        s_bvalid,
    input  logic                        s_bready,
    output logic [1:0]                  s_bresp,
    output logic                        pe_valid,
    input  logic                        pe_ready,
    output logic [3:0]                  pe_src_x,
    output logic [3:0]                  pe_src_y,
    output logic [MSG_WIDTH-17:0]       pe_payload,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [15:0]                 drop_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    // Stored entries drop the destination byte: only source and payload reach the PE.
    localparam int ENT_W = MSG_WIDTH - 8;
    localparam logic [3:0]       LOCAL_X = 4'(LOCAL_ADR % SIZE_X);
    localparam logic [3:0]       LOCAL_Y = 4'((LOCAL_ADR / SIZE_X) % SIZE_Y);
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);
    localparam logic [1:0]       RESP_OKAY   = 2'b00;
    localparam logic [1:0]       RESP_SLVERR = 2'b10;
    localparam logic [1:0]       RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_RESP  = 2'd2
    } state_e;

`ifdef NI_PARITY_CHECK_EN
    function automatic logic parity_ok_f(input logic [MSG_WIDTH-1:0] msg);
        return ~(^msg);
    endfunction
`endif

    state_e                  state_q, state_d;
    logic                    aw_flag_q, aw_flag_d;
    logic                    w_flag_q, w_flag_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [MSG_WIDTH-1:0]    wdata_q, wdata_d;
    logic                    awready_q, awready_d;
    logic                    wready_q, wready_d;
    logic                    bvalid_q, bvalid_d;
    logic [1:0]              bresp_q, bresp_d;
    logic [15:0]             drop_q, drop_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]        level_q, level_d;
    logic                    pe_valid_q, pe_valid_d;
    logic [ENT_W-1:0]        mem_q [FIFO_DEPTH];

    logic                    aw_hs_s, w_hs_s, push_s, pop_s, drop_inc_s, dst_match_s;
    logic [ENT_W-1:0]        head_s;
    logic                    unused_awaddr_s;

    assign aw_hs_s     = s_awvalid & awready_q;
    assign w_hs_s      = s_wvalid & wready_q;
    assign pop_s       = pe_valid_q & pe_ready;
    assign dst_match_s = (wdata_q[MSG_WIDTH-1 -: 4] == LOCAL_X) &&
                         (wdata_q[MSG_WIDTH-5 -: 4] == LOCAL_Y);
    // The write address is captured for protocol completeness but never decoded.
    assign unused_awaddr_s = ^awaddr_q;

    // Transaction FSM: channel capture, destination/parity check and response hold.
    always_comb begin
        state_d    = state_q;
        aw_flag_d  = aw_flag_q;
        w_flag_d   = w_flag_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        push_s     = 1'b0;
        drop_inc_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (aw_hs_s) begin
                    aw_flag_d = 1'b1;
                    awaddr_d  = s_awaddr;
                end else begin
                    aw_flag_d = aw_flag_q;
                end
                if (w_hs_s) begin
                    w_flag_d = 1'b1;
                    wdata_d  = s_wdata;
                end else begin
                    w_flag_d = w_flag_q;
                end
                if (aw_flag_d && w_flag_d) begin
                    state_d = S_CHECK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CHECK: begin
`ifdef NI_PARITY_CHECK_EN
                if (!parity_ok_f(wdata_q)) begin
                    bresp_d    = RESP_SLVERR;
                    drop_inc_s = 1'b1;
                end else if (dst_match_s) begin
                    bresp_d = RESP_OKAY;
                    push_s  = 1'b1;
                end else begin
                    bresp_d    = RESP_DECERR;
                    drop_inc_s = 1'b1;
                end
`else
                if (dst_match_s) begin
                    bresp_d = RESP_OKAY;
                    push_s  = 1'b1;
                end else begin
                    bresp_d    = RESP_DECERR;
                    drop_inc_s = 1'b1;
                end
`endif
                bvalid_d = 1'b1;
                state_d  = S_RESP;
            end
            S_RESP: begin
                if (s_bready) begin
                    bvalid_d  = 1'b0;
                    aw_flag_d = 1'b0;
                    w_flag_d  = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d   = S_IDLE;
                bvalid_d  = 1'b0;
                aw_flag_d = 1'b0;
                w_flag_d  = 1'b0;
            end
        endcase
    end

    // FIFO bookkeeping, drop counter and the registered ready/valid outputs derived from next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        drop_d   = drop_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        if (drop_inc_s && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end else begin
            drop_d = drop_q;
        end
        awready_d  = (state_d == S_IDLE) && !aw_flag_d && (level_d < DEPTH_L);
        wready_d   = (state_d == S_IDLE) && !w_flag_d && (level_d < DEPTH_L);
        pe_valid_d = (level_d != LVL_W'(0));
    end

    // Control and status registers; reset discards any in-flight write and flushes the FIFO.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= S_IDLE;
            aw_flag_q  <= 1'b0;
            w_flag_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            drop_q     <= 16'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            pe_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            aw_flag_q  <= aw_flag_d;
            w_flag_q   <= w_flag_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            drop_q     <= drop_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            pe_valid_q <= pe_valid_d;
        end
    end

    // Receive FIFO storage; contents are don't-care until the pointers mark them valid.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wdata_q[ENT_W-1:0];
        end
    end

    assign head_s     = mem_q[rd_ptr_q];
    assign s_awready  = awready_q;
    assign s_wready   = wready_q;
    assign s_bvalid   = bvalid_q;
    assign s_bresp    = bresp_q;
    assign pe_valid   = pe_valid_q;
    assign pe_src_x   = head_s[ENT_W-1 -: 4];
    assign pe_src_y   = head_s[ENT_W-5 -: 4];
    assign pe_payload = head_s[MSG_WIDTH-17:0];
    assign fifo_level = level_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_noc_ni_rx_responder.sv
// Self-checking bench for noc_ni_rx_responder: spec-level transaction/queue model compared every cycle, plus directed literal checks.
module tb_noc_ni_rx_responder;

    localparam int MW = 128;
    localparam int PW = MW - 16;
    localparam int DEPTH = 8;
    localparam int LADR = 5;
    localparam int LX = LADR % 4;
    localparam int LY = LADR / 4;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          s_awvalid = 1'b0;
    logic [7:0]    s_awaddr = 8'h00;
    logic          s_wvalid = 1'b0;
    logic [MW-1:0] s_wdata = '0;
    logic          s_bready = 1'b0;
    logic          pe_ready = 1'b0;
    logic          s_awready, s_wready, s_bvalid, pe_valid;
    logic [1:0]    s_bresp;
    logic [3:0]    pe_src_x, pe_src_y;
    logic [PW-1:0] pe_payload;
    logic [3:0]    fifo_level;
    logic [15:0]   drop_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    noc_ni_rx_responder #(
        .MSG_WIDTH(MW), .ADDR_WIDTH(8), .FIFO_DEPTH(DEPTH),
        .LOCAL_ADR(LADR), .SIZE_X(4), .SIZE_Y(4)
    ) dut (
        .clk(clk), .arst_n(arst_n),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .pe_valid(pe_valid), .pe_ready(pe_ready),
        .pe_src_x(pe_src_x), .pe_src_y(pe_src_y), .pe_payload(pe_payload),
        .fifo_level(fifo_level), .drop_cnt(drop_cnt)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [MW-1:0] mk(input logic [3:0] dx, input logic [3:0] dy,
                                          input logic [3:0] sx, input logic [3:0] sy,
                                          input logic [PW-1:0] p);
        logic [MW-1:0] r;
        r = {dx, dy, sx, sy, p};
        r[0] = 1'b0;
        r[0] = ^r;
        return r;
    endfunction

    // ---------------- behavioural model ----------------
    logic [MW-1:0] q_m[$];
    int            phase_m = 0;   // 0 accepting, 1 checking, 2 responding
    bit            aw_got_m = 0, w_got_m = 0, live_m = 0;
    logic [MW-1:0] wd_m = '0;
    logic [1:0]    resp_m = 2'b00;
    int            drop_m = 0;
    // late-cycle snapshot of what the next rising edge will see
    bit            sn_aw_hs = 0, sn_w_hs = 0, sn_bready = 0, sn_pe_ready = 0;
    logic [MW-1:0] sn_wdata = '0;

    initial forever begin
        @(negedge clk);
        #3;
        sn_aw_hs    = s_awvalid && s_awready;
        sn_w_hs     = s_wvalid && s_wready;
        sn_wdata    = s_wdata;
        sn_bready   = s_bready;
        sn_pe_ready = pe_ready;
    end

    initial forever begin
        @(posedge clk or negedge arst_n);
        if (!arst_n) begin
            q_m.delete();
            phase_m = 0; aw_got_m = 0; w_got_m = 0; live_m = 0;
            resp_m = 2'b00; drop_m = 0;
        end else begin
            bit bad;
            if (q_m.size() != 0 && sn_pe_ready) void'(q_m.pop_front());
            case (phase_m)
                0: begin
                    if (sn_aw_hs) aw_got_m = 1;
                    if (sn_w_hs) begin w_got_m = 1; wd_m = sn_wdata; end
                    if (aw_got_m && w_got_m) phase_m = 1;
                end
                1: begin
`ifdef NI_PARITY_CHECK_EN
                    bad = (^wd_m) != 1'b0;
`else
                    bad = 0;
`endif
                    if (bad) begin
                        resp_m = 2'b10;
                        if (drop_m < 65535) drop_m++;
                    end else if (wd_m[127:124] == 4'(LX) && wd_m[123:120] == 4'(LY)) begin
                        resp_m = 2'b00;
                        q_m.push_back(wd_m);
                    end else begin
                        resp_m = 2'b11;
                        if (drop_m < 65535) drop_m++;
                    end
                    phase_m = 2;
                end
                default: begin
                    if (sn_bready) begin phase_m = 0; aw_got_m = 0; w_got_m = 0; end
                end
            endcase
            live_m = 1;
        end
    end

    // every-cycle comparison against the model, away from the active edge
    initial forever begin
        @(posedge clk);
        #2;
        chk("awready", s_awready, live_m && phase_m == 0 && !aw_got_m && q_m.size() < DEPTH);
        chk("wready", s_wready, live_m && phase_m == 0 && !w_got_m && q_m.size() < DEPTH);
        chk("bvalid", s_bvalid, phase_m == 2);
        chk("bresp", s_bresp, resp_m);
        chk("pe_valid", pe_valid, q_m.size() != 0);
        chk("fifo_level", fifo_level, q_m.size());
        chk("drop_cnt", drop_cnt, drop_m);
        if (q_m.size() != 0) begin
            chk("pe_src_x", pe_src_x, q_m[0][119:116]);
            chk("pe_src_y", pe_src_y, q_m[0][115:112]);
            chk("pe_payload", pe_payload, q_m[0][111:0]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_write(input logic [MW-1:0] d, input int aw_dly, input int w_dly, input int b_dly,
                            output logic [1:0] resp, output int lat);
        bit aw_done = 0, w_done = 0, b_done = 0;
        int bw = 0, acc = -1, first_b = -1;
        logic [1:0] held = 2'b00;
        resp = 2'bxx;
        s_wdata = d;
        s_awaddr = 8'h5a;
        for (int cyc = 0; cyc < 300 && !b_done; cyc++) begin
            if (s_bvalid) begin
                bw++;
                if (bw == 1) begin
                    first_b = cyc;
                    held = s_bresp;
                end else begin
                    chk("bresp_stable", s_bresp, held);
                    chk("awready_during_resp", s_awready, 1'b0);
                end
            end
            s_bready  = s_bvalid && (bw > b_dly);
            s_awvalid = (!aw_done && cyc >= aw_dly) || (aw_done && s_bvalid && !s_bready);
            s_wvalid  = !w_done && cyc >= w_dly;
            if (!aw_done && s_awvalid && s_awready) begin aw_done = 1; if (cyc > acc) acc = cyc; end
            if (s_wvalid && s_wready) begin w_done = 1; if (cyc > acc) acc = cyc; end
            if (s_bvalid && s_bready) begin b_done = 1; resp = s_bresp; end
            @(negedge clk);
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
        if (!b_done) begin
            tests++; fails++;
            $display("FAIL write_timeout: no response, required one within 300 cycles");
        end
        lat = first_b - acc;
    endtask

    task automatic pop_one();
        pe_ready = 1'b1;
        @(negedge clk);
        pe_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before 500000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]    r, r9;
        int            lat, lat9;
        logic [MW-1:0] m;
        logic [PW-1:0] pays[9];

        // 1: reset values, readies rise one cycle after release
        repeat (3) @(negedge clk);
        chk("rst_awready", s_awready, 1'b0);
        chk("rst_wready", s_wready, 1'b0);
        chk("rst_bvalid", s_bvalid, 1'b0);
        chk("rst_bresp", s_bresp, 2'b00);
        chk("rst_pe_valid", pe_valid, 1'b0);
        chk("rst_level", fifo_level, 4'd0);
        chk("rst_drop", drop_cnt, 16'd0);
        arst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_awready", s_awready, 1'b1);
        chk("post_rst_wready", s_wready, 1'b1);

        // 2: matching message, AW and W together
        m = mk(4'd1, 4'd1, 4'd3, 4'd2, 112'h1234);
        do_write(m, 0, 0, 0, r, lat);
        chk("t2_bresp", r, 2'b00);
        chk("t2_latency", lat, 2);
        chk("t2_pe_valid", pe_valid, 1'b1);
        chk("t2_src_x", pe_src_x, 4'd3);
        chk("t2_src_y", pe_src_y, 4'd2);
        chk("t2_payload", pe_payload, 112'h1234);
        pop_one();
        chk("t2_popped", pe_valid, 1'b0);

        // 3: W three cycles ahead of AW, wrong destination
        m = mk(4'd2, 4'd1, 4'd0, 4'd0, 112'hbeef);
        do_write(m, 3, 0, 0, r, lat);
        chk("t3_bresp", r, 2'b11);
        chk("t3_pe_valid", pe_valid, 1'b0);
        chk("t3_drop", drop_cnt, 16'd1);

        // 5: response held off five cycles
        m = mk(4'd1, 4'd1, 4'd0, 4'd1, 112'h55);
        do_write(m, 0, 0, 5, r, lat);
        chk("t5_bresp", r, 2'b00);
        pop_one();
        pop_one();   // pop while empty is ignored
        chk("t5_level", fifo_level, 4'd0);

        // 4: fill FIFO, ninth write stalls until one pop
        for (int i = 0; i < 8; i++) begin
            m = mk(4'd1, 4'd1, 4'(i), 4'(15 - i), 112'(32'hA000 + i * 3));
            pays[i] = m[111:0];
            do_write(m, 0, i % 2, 0, r, lat);
            chk("t4_fill_bresp", r, 2'b00);
        end
        chk("t4_full_level", fifo_level, 4'd8);
        m = mk(4'd1, 4'd1, 4'd9, 4'd9, 112'hC0FFEE);
        pays[8] = m[111:0];
        fork
            do_write(m, 0, 0, 0, r9, lat9);
            begin
                repeat (3) @(negedge clk);
                chk("t4_full_awready", s_awready, 1'b0);
                chk("t4_full_wready", s_wready, 1'b0);
                chk("t4_head", pe_payload, pays[0]);
                pop_one();
            end
        join
        chk("t4_ninth_bresp", r9, 2'b00);
        for (int i = 1; i < 9; i++) begin
            chk("t4_order", pe_payload, pays[i]);
            pop_one();
        end
        chk("t4_drained", pe_valid, 1'b0);

        // 6: odd-parity message addressed here
        m = {4'd1, 4'd1, 4'd3, 4'd2, 112'h3};
        do_write(m, 0, 0, 0, r, lat);
`ifdef NI_PARITY_CHECK_EN
        chk("t6_bresp", r, 2'b10);
        chk("t6_pe_valid", pe_valid, 1'b0);
        chk("t6_drop", drop_cnt, 16'd2);
`else
        chk("t6_bresp", r, 2'b00);
        chk("t6_pe_valid", pe_valid, 1'b1);
        chk("t6_payload", pe_payload, 112'h3);
        chk("t6_drop", drop_cnt, 16'd1);
`endif
        pop_one();

        // reset in the middle of a transaction flushes everything
        m = mk(4'd1, 4'd1, 4'd4, 4'd4, 112'h77);
        do_write(m, 0, 0, 0, r, lat);
        s_wdata = mk(4'd1, 4'd1, 4'd5, 4'd5, 112'h88);
        s_wvalid = 1'b1;
        @(negedge clk);
        s_wvalid = 1'b0;
        @(negedge clk);
        arst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_level", fifo_level, 4'd0);
        chk("mid_rst_bvalid", s_bvalid, 1'b0);
        chk("mid_rst_drop", drop_cnt, 16'd0);
        arst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_awready", s_awready, 1'b1);
        m = mk(4'd1, 4'd1, 4'd6, 4'd6, 112'h99);
        do_write(m, 2, 0, 1, r, lat);
        chk("after_rst_bresp", r, 2'b00);
        chk("after_rst_level", fifo_level, 4'd1);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/noc_ni_rx_responder.md
Name: noc_ni_rx_responder

Overview:
AXI-Lite write responder at the processing-element end of a mesh router's NI egress link; the router's NI output is the initiator.
- Accepts one routed message per write transaction.
- Checks that the destination coordinates match this node; matching messages go into an internal receive FIFO.
- Presents buffered messages to the PE on a valid/ready stream, split into source coordinates and payload.

Parameters:
MSG_WIDTH, 128, message width; wdata width.
ADDR_WIDTH, 8, awaddr width; address is ignored.
FIFO_DEPTH, 8, receive FIFO entries; power of 2, >=2.
LOCAL_ADR, 0, linear node index.
SIZE_X, 4, mesh columns.
SIZE_Y, 4, mesh rows.

Ports:
clk  in  1  clock
arst_n  in  1  reset
s_awvalid  in  1  write address valid
s_awready  out  1  write address ready
s_awaddr  in  ADDR_WIDTH  write address, ignored
s_wvalid  in  1  write data valid
s_wready  out  1  write data ready
s_wdata  in  MSG_WIDTH  message
s_bvalid  out  1  write response valid
s_bready  in  1  write response ready
s_bresp  out  2  write response: OKAY 2'b00, SLVERR 2'b10, DECERR 2'b11
pe_valid  out  1  message available to PE
pe_ready  in  1  PE accepts message
pe_src_x  out  4  source x coordinate
pe_src_y  out  4  source y coordinate
pe_payload  out  MSG_WIDTH-16  payload
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
drop_cnt  out  16  dropped-message count, saturating

Behaviour:
- Clock and reset: single clock clk, rising edge. Reset arst_n is asynchronous assert, active-low, released synchronously to clk.
- Reset values: s_awready=0, s_wready=0, s_bvalid=0, s_bresp=2'b00, pe_valid=0, fifo_level=0, drop_cnt=0, FSM in IDLE.
- Reset asserted mid-transaction: the in-flight write is discarded with no response, and the FIFO is flushed.
- Message fields:
  - [MSG_WIDTH-1:MSG_WIDTH-4]=dst_x
  - next 4 bits = dst_y
  - next 4 bits = src_x
  - next 4 bits = src_y
  - [MSG_WIDTH-17:0]=payload
- Local coordinates: LOCAL_X=LOCAL_ADR%SIZE_X, LOCAL_Y=LOCAL_ADR/SIZE_X.
- FSM states and transitions:
  - IDLE: s_awready = s_wready = (fifo_level<FIFO_DEPTH).
    - AW and W channels are captured independently, each as a 1-bit flag plus data register.
    - A channel's ready drops once that channel has been captured.
    - When both channels are captured (same cycle or different cycles), go to CHECK.
  - CHECK, one cycle, both readies 0.
    - dst match: push message into FIFO, bresp=OKAY.
    - dst mismatch: no push, bresp=DECERR, drop_cnt+1 (saturates at 16'hFFFF).
    - Always go to RESP.
  - RESP: s_bvalid=1 with bresp held stable until s_bready; on the handshake cycle, clear the capture flags and go to IDLE.
- Latency: AW and W both accepted in cycle t -> CHECK at t+1 -> s_bvalid=1 and pe_valid=1 (if the FIFO was empty) at t+2.
- Only one transaction is outstanding at a time.
- FIFO: registered, show-ahead.
  - pe_* outputs are the head entry whenever pe_valid=1.
  - A pop occurs when pe_valid&pe_ready.
  - Push and pop in the same cycle: level unchanged.
  - Pop while empty: ignored.
  - Push never occurs when full; full FIFO means readies stay 0 in IDLE.
  - Pointers wrap modulo FIFO_DEPTH.
- s_awaddr is never decoded. wstrb is not supported.

Optional Feature:
Macro NI_PARITY_CHECK_EN.
- When defined: s_wdata[0] is the even-parity bit over the whole message (XOR of all MSG_WIDTH bits must be 0).
  - In CHECK, a parity failure takes priority over the dst check: bresp=SLVERR, no push, drop_cnt+1.
- When undefined: bit 0 is ordinary payload, and SLVERR is never returned.

Test Plan:
1. Reset with LOCAL_ADR=5, SIZE_X=SIZE_Y=4 (local x=1, y=1) -> all outputs at reset values; s_awready=s_wready=1 one cycle after release.
2. AW+W same cycle, wdata dst=(1,1) src=(3,2) payload=112'h1234 -> s_bvalid=1, bresp=00 two cycles later; pe_valid=1, pe_src_x=3, pe_src_y=2, pe_payload=112'h1234.
3. W asserted 3 cycles before AW, dst=(2,1) -> bresp=11, pe_valid stays 0, drop_cnt=1.
4. pe_ready=0, 8 valid writes with FIFO_DEPTH=8 -> fifo_level=8 and readies held 0 on a 9th write; pulse pe_ready one cycle -> 9th write completes with OKAY; order of all 9 payloads preserved.
5. s_bready held 0 for 5 cycles -> s_bvalid and bresp stable; no new AW accepted until the handshake.
6. With NI_PARITY_CHECK_EN, dst=(1,1) and odd parity -> bresp=10, no push, drop_cnt+1; the same stimulus with the macro undefined -> bresp=00 and the message is pushed.
